// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, window width and reset constants for the core-local interruptor
package clint_pkg;
  localparam int CLINT_WIN_W = 16;
  localparam logic [CLINT_WIN_W-1:0] CLINT_MSIP        = 16'h0000;
  localparam logic [CLINT_WIN_W-1:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [CLINT_WIN_W-1:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [CLINT_WIN_W-1:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [CLINT_WIN_W-1:0] CLINT_MTIME_HI    = 16'hBFFC;
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
endpackage

// File: rtl/clint_timer_prescaler.sv
// clint_prescaler: divides clk into one tick every PRESCALE cycles, restartable by clr
module clint_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [W-1:0] pcnt;
  assign tick = pcnt == W'(PRESCALE - 1);
  always_ff @(posedge clk)
    if (rst || clr || tick) pcnt <= '0;
    else pcnt <= pcnt + 1'b1;
endmodule

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped mtime/mtimecmp/msip block driving machine timer and software interrupts
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h0200_0000,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] d_in,
  input  logic        mrd,
  input  logic        mwr,
  input  logic [3:0]  data_out_mask,
  output logic [31:0] d_out,
  output logic        hit,
  output logic        machine_timer_interrupt,
  output logic        machine_software_interrupt
);
  logic [63:0] mtime, mtimecmp;
  logic msip, tick, wr;
  logic we_msip, we_clo, we_chi, we_tlo, we_thi;
  logic [CLINT_WIN_W-1:0] off;
  logic [31:0] wd_msip, wd_clo, wd_chi, wd_tlo, wd_thi, rdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = m[i] ? d[8*i+:8] : old[8*i+:8];
    return r;
  endfunction

  assign hit = adr[31:CLINT_WIN_W] == BASE_ADR[31:CLINT_WIN_W];
  assign off = adr[CLINT_WIN_W-1:0] & ~CLINT_WIN_W'(3);
  // an all-zero mask is a true no-op, so it must not count as an mtime write
  assign wr = hit & mwr & |data_out_mask;
  assign we_msip = wr && off == CLINT_MSIP;
  assign we_clo  = wr && off == CLINT_MTIMECMP_LO;
  assign we_chi  = wr && off == CLINT_MTIMECMP_HI;
  assign we_tlo  = wr && off == CLINT_MTIME_LO;
  assign we_thi  = wr && off == CLINT_MTIME_HI;

  assign wd_msip = merge({31'b0, msip}, d_in, data_out_mask);
  assign wd_clo  = merge(mtimecmp[31:0], d_in, data_out_mask);
  assign wd_chi  = merge(mtimecmp[63:32], d_in, data_out_mask);
  assign wd_tlo  = merge(mtime[31:0], d_in, data_out_mask);
  assign wd_thi  = merge(mtime[63:32], d_in, data_out_mask);

  clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (we_tlo | we_thi),
    .tick(tick)
  );

  always_ff @(posedge clk)
    if (rst) begin
      mtime                      <= '0;
      mtimecmp                   <= CLINT_MTIMECMP_RST;
      msip                       <= 1'b0;
      machine_timer_interrupt    <= 1'b0;
      machine_software_interrupt <= 1'b0;
    end else begin
      if (we_msip) msip <= wd_msip[0];
      if (we_clo) mtimecmp[31:0] <= wd_clo;
      if (we_chi) mtimecmp[63:32] <= wd_chi;
      // a software write to either half replaces that cycle's increment, no carry across halves
      if (we_tlo) mtime <= {mtime[63:32], wd_tlo};
      else if (we_thi) mtime <= {wd_thi, mtime[31:0]};
      else if (tick) mtime <= mtime + 64'd1;
      machine_timer_interrupt    <= mtime >= mtimecmp;
      machine_software_interrupt <= msip;
    end

  always_comb begin
    rdata = off == CLINT_MSIP        ? {31'b0, msip}    :
            off == CLINT_MTIMECMP_LO ? mtimecmp[31:0]   :
            off == CLINT_MTIMECMP_HI ? mtimecmp[63:32]  :
            off == CLINT_MTIME_LO    ? mtime[31:0]      :
            off == CLINT_MTIME_HI    ? mtime[63:32]     : 32'b0;
    d_out = hit && mrd ? rdata : 32'b0;
  end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: randomized and directed checks of two clint_timer instances (PRESCALE 4 and 1) against a behavioural model
module tb_clint_timer;
  logic clk = 0, rst = 1, mrd = 0, mwr = 0;
  logic [31:0] adr = 0, d_in = 0;
  logic [3:0] mask = 0;
  logic [31:0] dout [2];
  logic hit [2], mti [2], msi [2];
  logic chk_en = 0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  clint_timer #(.PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .adr(adr), .d_in(d_in), .mrd(mrd), .mwr(mwr), .data_out_mask(mask),
    .d_out(dout[0]), .hit(hit[0]), .machine_timer_interrupt(mti[0]), .machine_software_interrupt(msi[0]));
  clint_timer #(.PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .adr(adr), .d_in(d_in), .mrd(mrd), .mwr(mwr), .data_out_mask(mask),
    .d_out(dout[1]), .hit(hit[1]), .machine_timer_interrupt(mti[1]), .machine_software_interrupt(msi[1]));

  typedef struct {
    logic [63:0] mtime, cmp;
    logic msip, mtip, msip_o;
    int pcnt;
  } mdl_t;
  mdl_t m [2];

  function automatic mdl_t mreset();
    mdl_t n;
    n.mtime = 0; n.cmp = '1; n.msip = 0; n.mtip = 0; n.msip_o = 0; n.pcnt = 0;
    return n;
  endfunction

  function automatic logic [31:0] bm(logic [31:0] old, logic [31:0] d, logic [3:0] mk);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = mk[i] ? d[8*i+:8] : old[8*i+:8];
    return r;
  endfunction

  function automatic mdl_t step(mdl_t c, int p, logic [31:0] a, logic [31:0] d, logic w, logic [3:0] mk);
    mdl_t n;
    logic [15:0] o;
    logic we;
    n = c;
    o = a[15:0] & 16'hFFFC;
    we = w && a[31:16] == 16'h0200 && mk != 0;
    n.mtip = c.mtime >= c.cmp;
    n.msip_o = c.msip;
    if (c.pcnt == p - 1) begin n.pcnt = 0; n.mtime = c.mtime + 1; end
    else n.pcnt = c.pcnt + 1;
    if (we)
      case (o)
        16'h0000: n.msip = mk[0] ? d[0] : c.msip;
        16'h4000: n.cmp[31:0] = bm(c.cmp[31:0], d, mk);
        16'h4004: n.cmp[63:32] = bm(c.cmp[63:32], d, mk);
        16'hBFF8: begin n.mtime = {c.mtime[63:32], bm(c.mtime[31:0], d, mk)}; n.pcnt = 0; end
        16'hBFFC: begin n.mtime = {bm(c.mtime[63:32], d, mk), c.mtime[31:0]}; n.pcnt = 0; end
        default: ;
      endcase
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(mdl_t c, logic [31:0] a, logic rd);
    if (!(rd && a[31:16] == 16'h0200)) return 0;
    case (a[15:0] & 16'hFFFC)
      16'h0000: return {31'b0, c.msip};
      16'h4000: return c.cmp[31:0];
      16'h4004: return c.cmp[63:32];
      16'hBFF8: return c.mtime[31:0];
      16'hBFFC: return c.mtime[63:32];
      default:  return 0;
    endcase
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 2; i++) m[i] <= rst ? mreset() : step(m[i], i == 0 ? 4 : 1, adr, d_in, mwr, mask);

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk)
    if (chk_en)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("hit%0d", i), 64'(hit[i]), 64'(adr[31:16] == 16'h0200));
        chk($sformatf("dout%0d", i), 64'(dout[i]), 64'(exp_rd(m[i], adr, mrd)));
        chk($sformatf("mtip%0d", i), 64'(mti[i]), 64'(m[i].mtip));
        chk($sformatf("msip%0d", i), 64'(msi[i]), 64'(m[i].msip_o));
      end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    mrd = 0; mwr = 0; adr = 0; d_in = 0; mask = 0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] mk);
    adr = a; d_in = d; mask = mk; mwr = 1;
    nxt();
    idle();
  endtask

  task automatic lit(string nm, logic [31:0] a, logic [31:0] e4, logic [31:0] e1);
    adr = a; mrd = 1;
    @(negedge clk);
    chk({nm, "_p4"}, 64'(dout[0]), 64'(e4));
    chk({nm, "_p1"}, 64'(dout[1]), 64'(e1));
    nxt();
    idle();
  endtask

  initial begin
    logic s4, s1;
    logic [31:0] r;
    nxt();
    chk_en = 1;
    nxt();
    lit("rst_mtime", 32'h0200_BFF8, 0, 0);
    lit("rst_cmp_hi", 32'h0200_4004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("rst_irq", {mti[0], mti[1], msi[0], msi[1]}, 0);
    rst = 0;
    repeat (40) @(posedge clk);
    #1;
    lit("count40", 32'h0200_BFF8, 10, 40);

    wr(32'h0200_BFFC, 0, 4'hF);
    wr(32'h0200_BFF8, 0, 4'hF);
    wr(32'h0200_4004, 0, 4'hF);
    wr(32'h0200_4000, 32'h20, 4'hF);
    adr = 32'h0200_BFF8; mrd = 1; s4 = 0; s1 = 0;
    for (int k = 0; k < 400 && !(s4 && s1); k++) begin
      @(negedge clk);
      if (!s4 && mti[0]) begin chk("mtip_rise_p4", 64'(dout[0]), 64'h20); s4 = 1; end
      if (!s1 && mti[1]) begin chk("mtip_rise_p1", 64'(dout[1]), 64'h21); s1 = 1; end
    end
    chk("mtip_seen", {s4, s1}, 2'b11);
    nxt();
    idle();
    wr(32'h0200_4000, 32'h100, 4'hF);
    @(negedge clk);
    chk("mtip_hold", {mti[0], mti[1]}, 2'b11);
    nxt();
    @(negedge clk);
    chk("mtip_fall", {mti[0], mti[1]}, 2'b00);
    nxt();

    wr(32'h0200_BFFC, 0, 4'hF);
    wr(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF);
    nxt();
    lit("carry_hi", 32'h0200_BFFC, 0, 1);
    wr(32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF);
    nxt();
    lit("wrap_hi", 32'h0200_BFFC, 32'hFFFF_FFFF, 0);
    lit("wrap_lo", 32'h0200_BFF8, 32'hFFFF_FFFF, 1);

    wr(32'h0200_0000, 1, 4'b0001);
    @(negedge clk);
    chk("msip_lat", {msi[0], msi[1]}, 2'b00);
    nxt();
    @(negedge clk);
    chk("msip_set", {msi[0], msi[1]}, 2'b11);
    nxt();
    wr(32'h0200_0000, 0, 4'b0000);
    nxt();
    @(negedge clk);
    chk("msip_mask0", {msi[0], msi[1]}, 2'b11);
    nxt();
    wr(32'h0200_0000, 0, 4'hF);
    nxt();
    @(negedge clk);
    chk("msip_clr", {msi[0], msi[1]}, 2'b00);
    nxt();

    adr = 32'h0000_1000; mrd = 1; mwr = 1; d_in = $urandom; mask = 4'hF;
    @(negedge clk);
    chk("outside", {hit[0], hit[1], dout[0], dout[1]}, 0);
    nxt();
    idle();

    for (int k = 0; k < 8 && m[0].pcnt != 3; k++) nxt();
    chk("tick_phase", 64'(m[0].pcnt), 3);
    adr = 32'h0200_BFF8; d_in = 32'h55; mask = 4'hF; mwr = 1; mrd = 1;
    nxt();
    mwr = 0; mask = 0;
    @(negedge clk);
    chk("coll_p4", 64'(dout[0]), 64'h55);
    chk("coll_p1", 64'(dout[1]), 64'h55);
    nxt();
    idle();

    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 7);
      adr = r == 0 || r == 7 ? 32'h0200_0000 : r == 1 ? 32'h0200_4000 : r == 2 ? 32'h0200_4004 :
            r == 3 ? 32'h0200_BFF8 : r == 4 ? 32'h0200_BFFC : r == 5 ? {16'h0200, 16'($urandom)} : $urandom;
      adr[1:0] = 2'($urandom);
      d_in = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 300);
      mask = 4'($urandom);
      mrd = 1'($urandom);
      mwr = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 60) == 0;
      nxt();
    end
    rst = 0;
    idle();
    repeat (3) nxt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped core-local interruptor for the RV32I trap pipeline. Holds the 64-bit `mtime` counter, the 64-bit `mtimecmp` comparator and the 1-bit `msip` register, all reachable over the CPU data-memory bus in parallel with `data_mem`. It drives `machine_timer_interrupt` and `machine_software_interrupt` directly into `riscv_pipeline`, replacing bench-driven stimulus on those two lines.

## Interface
Parameters:
- `BASE_ADR`, 32'h0200_0000: 64 KiB-aligned window base; hit when `adr[31:16] == BASE_ADR[31:16]`.
- `PRESCALE`, 1: `clk` cycles per `mtime` increment; legal range ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `adr`  in  32  data address, shared with `data_mem`.
- `d_in`  in  32  write data.
- `mrd`  in  1  read strobe.
- `mwr`  in  1  write strobe.
- `data_out_mask`  in  4  byte enables; bit i enables `d_in[8i+7:8i]`.
- `d_out`  out  32  read data; 0 when not selected.
- `hit`  out  1  combinational window select; the top level ORs `d_out` with `data_mem` and gates `data_mem` `mwr` with `~hit`.
- `machine_timer_interrupt`  out  1  registered MTIP.
- `machine_software_interrupt`  out  1  registered MSIP.

## Operation
- Register map, as offsets `adr[15:0]` with word alignment and `adr[1:0]` ignored:
  - 0x0000 `msip`: bit 0 only; other bits read 0.
  - 0x4000 `mtimecmp[31:0]`; 0x4004 `mtimecmp[63:32]`.
  - 0xBFF8 `mtime[31:0]`; 0xBFFC `mtime[63:32]`.
- Any other offset inside the window reads 0 and ignores writes.
- Writes are accepted when `hit & mwr`, byte-masked by `data_out_mask`, and take effect at the rising edge.
- Reads are combinational: `d_out` is valid in the same cycle as `hit & mrd` and returns the pre-edge register value. `d_out` = 0 when `!(hit & mrd)`.
- Prescaler:
  - Counter `pcnt` runs 0..PRESCALE-1; `tick` is asserted when `pcnt == PRESCALE-1`, and `pcnt` wraps to 0.
  - `mtime` increments by 1 on `tick`.
  - `mtime` wraps 2^64-1 → 0 with no flag.
- A write to either `mtime` half:
  - suppresses that cycle's increment;
  - clears `pcnt`;
  - leaves the other half unchanged (no carry into the written half).
- MTIP:
  - `machine_timer_interrupt` ← (`mtime >= mtimecmp`), 64-bit unsigned, evaluated on current register values each cycle.
  - Level-sensitive: it is cleared only by raising `mtimecmp` or lowering `mtime`.
- MSIP: `machine_software_interrupt` ← `msip` register, one register stage.
- Reset values: `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `msip` = 0, `pcnt` = 0, both interrupt outputs = 0, `d_out` = 0.

## Timing
- MTIP latency: if `mtime` becomes ≥ `mtimecmp` at edge N, the interrupt asserts at edge N+1. Same latency after a `mtimecmp` write at edge N.
- MSIP latency: a write at edge N gives an output change at edge N+1.
- 64-bit updates are non-atomic. Software writes `mtimecmp` high = all-ones, then low, then high. The block provides no shadowing; spurious MTIP between half-writes is software's responsibility.
- `rst` asserted mid-count or mid-write: reset wins that cycle, and every state returns to its reset value at the same edge.
- `mrd` and `mwr` asserted together on one register: the read returns the old value and the write commits at the edge.
- A masked write with `data_out_mask` = 0 is a no-op and does not suppress the increment.

## Structure
- Shared package or header `clint_pkg` holds:
  - offset constants `CLINT_MSIP`, `CLINT_MTIMECMP_LO/HI`, `CLINT_MTIME_LO/HI`;
  - the window width (16);
  - the `mtimecmp` reset constant.
- One natural sub-module, `clint_prescaler`: `clk`, `rst`, `clr` in; `tick` out; parameter `PRESCALE`.
- Byte-mask merge is a local function reused for all five writable words.

## Test plan
- Reset: after 2 cycles with `rst`=1, read 0xBFF8 → 0, 0x4004 → 0xFFFF_FFFF, and both interrupts are 0.
- Counting with PRESCALE=4: release reset and wait 40 cycles, then read 0xBFF8 → 10.
- Timer interrupt:
  - write `mtimecmp` = 0x0000_0000_0000_0020 (high, then low) → MTIP rises exactly 1 cycle after `mtime` reaches 0x20;
  - then write `mtimecmp` low = 0x100 → MTIP falls the next cycle.
- Carry and wrap:
  - write `mtime` = 0x0000_0000_FFFF_FFFF (PRESCALE=1), then read the high word 2 cycles later → 1;
  - write `mtime` = all-ones → next cycle `mtime` = 0.
- Software interrupt and byte masking:
  - write 0x0000_0001 to 0x0000 with mask 4'b0001 → MSIP = 1 next cycle;
  - write with mask 4'b0000 → MSIP unchanged;
  - write 0 → MSIP clears.
- Select and collision:
  - access to 0x0000_1000 (outside the window) gives `hit`=0 and `d_out`=0, with `data_mem` servicing the access;
  - a write to `mtime` low on a `tick` cycle loads the written value with no +1.
